// File: rtl/mercury_nseg_scan_pkg.sv
// Shared constants and helpers for the mercury display scanner family.
// PWM_STEPS : sub-slots per digit slot (sub 0 is the ghosting guard)
// SUB_W     : width of the sub-slot counter
// BRIGHT_W  : width of the brightness control
// sub_t     : sub-slot index type
// clog2_min1: counter width for a modulus, never below 1 bit
package mercury_nseg_scan_pkg;

  localparam int unsigned PWM_STEPS = 16;
  localparam int unsigned SUB_W     = 4;
  localparam int unsigned BRIGHT_W  = 4;

  typedef logic [SUB_W-1:0] sub_t;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mercury_nseg_scan_if.sv
// Application-to-pins bundle of the N-digit display scanner.
// master: application side, drives the display controls and reads the pins.
// slave : scanner side, reads the display controls and drives the pins.
//   enable, brightness, blink_mask, seg_in, dots_in : display controls
//   seg_out, dot_out, an_out, frame_stb             : registered pin outputs
interface mercury_nseg_scan_if
  import mercury_nseg_scan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SEG_W      = 7
);

  logic                        enable;
  logic [BRIGHT_W-1:0]         brightness;
  logic [NUM_DIGITS-1:0]       blink_mask;
  logic [NUM_DIGITS*SEG_W-1:0] seg_in;
  logic [NUM_DIGITS-1:0]       dots_in;
  logic [SEG_W-1:0]            seg_out;
  logic                        dot_out;
  logic [NUM_DIGITS-1:0]       an_out;
  logic                        frame_stb;

  modport master (
    output enable, brightness, blink_mask, seg_in, dots_in,
    input  seg_out, dot_out, an_out, frame_stb
  );

  modport slave (
    input  enable, brightness, blink_mask, seg_in, dots_in,
    output seg_out, dot_out, an_out, frame_stb
  );

endinterface

// File: rtl/mercury_nseg_scan_timebase.sv
// Free-running scan timebase: cyc -> sub -> dig -> frame_cnt, plus blink phase.
//   clk, rst        : clock, synchronous active-high reset
//   sub, dig        : current sub-slot and digit being scanned
//   blink_phase     : toggles when frame_cnt wraps
//   boundary_c      : current cycle is the frame boundary (cyc, sub, dig all max)
//   boundary_next_c : the next cycle will be the frame boundary
module mercury_nseg_scan_timebase
  import mercury_nseg_scan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SUB_CYCLES   = 781,
  parameter int unsigned BLINK_FRAMES = 250,
  localparam int unsigned DIG_W       = clog2_min1(NUM_DIGITS)
) (
  input  logic             clk,
  input  logic             rst,
  output sub_t             sub,
  output logic [DIG_W-1:0] dig,
  output logic             blink_phase,
  output logic             boundary_c,
  output logic             boundary_next_c
);

  localparam int unsigned      CYC_W   = clog2_min1(SUB_CYCLES);
  localparam int unsigned      FRM_W   = clog2_min1(BLINK_FRAMES);
  localparam logic [CYC_W-1:0] CYC_MAX = CYC_W'(SUB_CYCLES - 1);
  localparam sub_t             SUB_MAX = SUB_W'(PWM_STEPS - 1);
  localparam logic [DIG_W-1:0] DIG_MAX = DIG_W'(NUM_DIGITS - 1);
  localparam logic [FRM_W-1:0] FRM_MAX = FRM_W'(BLINK_FRAMES - 1);

  logic [CYC_W-1:0] cyc;
  logic [CYC_W-1:0] cyc_nxt;
  logic [FRM_W-1:0] frame_cnt;
  logic [FRM_W-1:0] frame_nxt;
  sub_t             sub_nxt;
  logic [DIG_W-1:0] dig_nxt;
  logic             phase_nxt;
  logic             cyc_wrap;
  logic             sub_wrap;
  logic             dig_wrap;
  logic             frm_wrap;

  // Chained counter increments; dig wraps explicitly so non-power-of-2 N stays in range.
  always_comb begin
    cyc_nxt         = cyc;
    sub_nxt         = sub;
    dig_nxt         = dig;
    frame_nxt       = frame_cnt;
    phase_nxt       = blink_phase;
    cyc_wrap        = (cyc == CYC_MAX);
    sub_wrap        = (sub == SUB_MAX);
    dig_wrap        = (dig == DIG_MAX);
    frm_wrap        = (frame_cnt == FRM_MAX);
    boundary_c      = cyc_wrap && sub_wrap && dig_wrap;

    cyc_nxt = cyc_wrap ? '0 : cyc + CYC_W'(1);
    if (cyc_wrap) begin
      sub_nxt = sub_wrap ? '0 : sub + SUB_W'(1);
      if (sub_wrap) begin
        dig_nxt = dig_wrap ? '0 : dig + DIG_W'(1);
      end
    end
    if (boundary_c) begin
      frame_nxt = frm_wrap ? '0 : frame_cnt + FRM_W'(1);
      if (frm_wrap) begin
        phase_nxt = ~blink_phase;
      end
    end

    boundary_next_c = (cyc_nxt == CYC_MAX) && (sub_nxt == SUB_MAX) && (dig_nxt == DIG_MAX);
  end

  // Counter state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc         <= '0;
      sub         <= '0;
      dig         <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      cyc         <= cyc_nxt;
      sub         <= sub_nxt;
      dig         <= dig_nxt;
      frame_cnt   <= frame_nxt;
      blink_phase <= phase_nxt;
    end
  end

endmodule

// File: rtl/mercury_nseg_scan.sv
// Time-multiplexed N-digit 7-segment+DP driver with PWM brightness, per-digit
// blink and frame-boundary capture of the display registers.
//   app_clk : clock, single domain
//   app_rst : synchronous active-high reset
//   bus     : slave side of mercury_nseg_scan_if (controls in, registered pins out)
module mercury_nseg_scan
  import mercury_nseg_scan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SEG_W        = 7,
  parameter int unsigned SUB_CYCLES   = 781,
  parameter int unsigned BLINK_FRAMES = 250,
  parameter int unsigned AN_ACT_LOW   = 1,
  parameter int unsigned SEG_ACT_LOW  = 0
) (
  input  logic                app_clk,
  input  logic                app_rst,
  mercury_nseg_scan_if.slave  bus
);

  localparam int unsigned           DIG_W   = clog2_min1(NUM_DIGITS);
  localparam logic                  AN_LOW  = (AN_ACT_LOW != 0);
  localparam logic                  SEG_LOW = (SEG_ACT_LOW != 0);
  // Idle pin levels; XOR with these also converts "1 = active" into pin polarity.
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_LOW}};
  localparam logic [SEG_W-1:0]      SEG_OFF = {SEG_W{SEG_LOW}};

  sub_t             sub;
  logic [DIG_W-1:0] dig;
  logic             blink_phase;
  logic             boundary_c;
  logic             boundary_next_c;

  logic                  enable_r;
  logic [BRIGHT_W-1:0]   bright_sh;
  logic [NUM_DIGITS-1:0] blink_sh;
  logic [NUM_DIGITS-1:0] dots_sh;
  logic [SEG_W-1:0]      seg_sh [NUM_DIGITS];

  logic                  lit_c;
  logic [NUM_DIGITS-1:0] an_nxt_c;
  logic [SEG_W-1:0]      seg_nxt_c;
  logic                  dot_nxt_c;

  logic [NUM_DIGITS-1:0] an_r;
  logic [SEG_W-1:0]      seg_r;
  logic                  dot_r;
  logic                  stb_r;

  mercury_nseg_scan_timebase #(
    .NUM_DIGITS   (NUM_DIGITS),
    .SUB_CYCLES   (SUB_CYCLES),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_timebase (
    .clk             (app_clk),
    .rst             (app_rst),
    .sub             (sub),
    .dig             (dig),
    .blink_phase     (blink_phase),
    .boundary_c      (boundary_c),
    .boundary_next_c (boundary_next_c)
  );

  // Shadow registers: loaded only on the frame boundary so pins never tear.
  always_ff @(posedge app_clk) begin
    if (app_rst) begin
      enable_r  <= 1'b0;
      bright_sh <= '0;
      blink_sh  <= '0;
      dots_sh   <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        seg_sh[i] <= '0;
      end
    end else begin
      enable_r <= bus.enable;
      if (boundary_c) begin
        bright_sh <= bus.brightness;
        blink_sh  <= bus.blink_mask;
        dots_sh   <= bus.dots_in;
        for (int i = 0; i < NUM_DIGITS; i++) begin
          seg_sh[i] <= bus.seg_in[i*SEG_W +: SEG_W];
        end
      end
    end
  end

  // Lit decision; sub 0 is always dark to hide digit-switch ghosting.
  always_comb begin
    an_nxt_c  = AN_OFF;
    seg_nxt_c = SEG_OFF;
    dot_nxt_c = SEG_LOW;
    lit_c     = enable_r && (sub != '0) && (sub <= bright_sh)
                && !(blink_sh[dig] && blink_phase);
    if (lit_c) begin
      an_nxt_c  = (NUM_DIGITS'(1) << dig) ^ AN_OFF;
      seg_nxt_c = seg_sh[dig] ^ SEG_OFF;
      dot_nxt_c = dots_sh[dig] ^ SEG_LOW;
    end
  end

  // Pin registers; frame_stb is pre-computed so it coincides with the capture cycle.
  always_ff @(posedge app_clk) begin
    if (app_rst) begin
      an_r  <= AN_OFF;
      seg_r <= SEG_OFF;
      dot_r <= SEG_LOW;
      stb_r <= 1'b0;
    end else begin
      an_r  <= an_nxt_c;
      seg_r <= seg_nxt_c;
      dot_r <= dot_nxt_c;
      stb_r <= boundary_next_c;
    end
  end

  assign bus.an_out    = an_r;
  assign bus.seg_out   = seg_r;
  assign bus.dot_out   = dot_r;
  assign bus.frame_stb = stb_r;

endmodule

// File: tb/tb_mercury_nseg_scan.sv
// Directed bench for mercury_nseg_scan: a 4-digit active-low-anode instance
// and a 3-digit inverted-polarity instance sharing clock and reset.
// With SUB_CYCLES=2 a digit slot is 32 cycles and a 4-digit frame 128 cycles.
module tb_mercury_nseg_scan;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mercury_nseg_scan_if #(.NUM_DIGITS(4), .SEG_W(7)) bus1 ();
  mercury_nseg_scan_if #(.NUM_DIGITS(3), .SEG_W(7)) bus2 ();

  mercury_nseg_scan #(
    .NUM_DIGITS(4), .SEG_W(7), .SUB_CYCLES(2), .BLINK_FRAMES(2),
    .AN_ACT_LOW(1), .SEG_ACT_LOW(0)
  ) dut (
    .app_clk (clk),
    .app_rst (rst),
    .bus     (bus1)
  );

  mercury_nseg_scan #(
    .NUM_DIGITS(3), .SEG_W(7), .SUB_CYCLES(2), .BLINK_FRAMES(2),
    .AN_ACT_LOW(0), .SEG_ACT_LOW(1)
  ) dut3 (
    .app_clk (clk),
    .app_rst (rst),
    .bus     (bus2)
  );

  int compared   = 0;
  int mismatched = 0;
  int t          = 0;   // rising edges since the last reset release

  // Per-frame observations of the 4-digit instance; sample i shows scan position i.
  int         lit_cnt   [4];
  int         first_pos [4];
  logic [6:0] seg_seen  [4];
  logic       dot_seen  [4];
  int         seg_var   [4];
  int         dark_bad;
  int         an_bad;
  int         stb_cnt;
  int         stb_pos;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    t++;
  endtask

  function automatic int dec4(input logic [3:0] a);
    case (a)
      4'b1111: return -1;
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -2;
    endcase
  endfunction

  function automatic int dec3(input logic [2:0] a);
    case (a)
      3'b000:  return -1;
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return -2;
    endcase
  endfunction

  // Observe 128 samples; optionally rewrite seg_in digit 0 after sample chg_idx.
  task automatic collect_frame(input int chg_idx, input logic [6:0] chg_val);
    int d;
    for (int k = 0; k < 4; k++) begin
      lit_cnt[k] = 0; first_pos[k] = -1; seg_seen[k] = '0; dot_seen[k] = 1'b0; seg_var[k] = 0;
    end
    dark_bad = 0; an_bad = 0; stb_cnt = 0; stb_pos = -1;
    for (int i = 0; i < 128; i++) begin
      tick();
      d = dec4(bus1.an_out);
      if (bus1.frame_stb === 1'b1) begin
        stb_cnt++;
        stb_pos = i;
      end
      if (d >= 0) begin
        if (lit_cnt[d] == 0) begin
          first_pos[d] = i;
          seg_seen[d]  = bus1.seg_out;
          dot_seen[d]  = bus1.dot_out;
        end else if (seg_seen[d] !== bus1.seg_out || dot_seen[d] !== bus1.dot_out) begin
          seg_var[d]++;
        end
        lit_cnt[d]++;
      end else if (d == -1) begin
        if (bus1.seg_out !== 7'h00 || bus1.dot_out !== 1'b0) dark_bad++;
      end else begin
        an_bad++;
      end
      if (i == chg_idx) bus1.seg_in[6:0] = chg_val;
    end
  endtask

  task automatic test_reset();
    int first_stb;
    int dark_viol;
    rst = 1'b1;
    bus1.enable = 1'b1; bus1.brightness = 4'd15; bus1.blink_mask = 4'b0000;
    bus1.seg_in = {7'h08, 7'h04, 7'h02, 7'h01}; bus1.dots_in = 4'b0101;
    bus2.enable = 1'b1; bus2.brightness = 4'd15; bus2.blink_mask = 3'b000;
    bus2.seg_in = {7'h04, 7'h02, 7'h01}; bus2.dots_in = 3'b010;
    repeat (3) tick();
    compared++; if (bus1.an_out !== 4'b1111) begin mismatched++; $display("FAIL reset_an: got %b want 1111", bus1.an_out); end
    compared++; if (bus1.seg_out !== 7'h00) begin mismatched++; $display("FAIL reset_seg: got %h want 00", bus1.seg_out); end
    compared++; if (bus1.dot_out !== 1'b0) begin mismatched++; $display("FAIL reset_dot: got %b want 0", bus1.dot_out); end
    compared++; if (bus1.frame_stb !== 1'b0) begin mismatched++; $display("FAIL reset_stb: got %b want 0", bus1.frame_stb); end
    compared++; if (bus2.an_out !== 3'b000) begin mismatched++; $display("FAIL reset_n3_an: got %b want 000", bus2.an_out); end
    compared++; if (bus2.seg_out !== 7'h7f) begin mismatched++; $display("FAIL reset_n3_seg: got %h want 7f", bus2.seg_out); end
    compared++; if (bus2.dot_out !== 1'b1) begin mismatched++; $display("FAIL reset_n3_dot: got %b want 1", bus2.dot_out); end
    rst = 1'b0;
    t = 0;
    first_stb = -1;
    dark_viol = 0;
    while (first_stb < 0 && t < 300) begin
      tick();
      if (bus1.frame_stb === 1'b1) first_stb = t;
      if (bus1.an_out !== 4'b1111) dark_viol++;
    end
    compared++; if (first_stb != 127) begin mismatched++; $display("FAIL first_stb_cycle: got %0d want 127", first_stb); end
    tick();
    if (bus1.an_out !== 4'b1111) dark_viol++;
    compared++; if (bus1.frame_stb !== 1'b0) begin mismatched++; $display("FAIL stb_one_cycle: got %b want 0", bus1.frame_stb); end
    compared++; if (dark_viol != 0) begin mismatched++; $display("FAIL dark_before_capture: got %0d lit samples want 0", dark_viol); end
  endtask

  task automatic test_scan();
    logic [6:0] exp_seg [4];
    logic       exp_dot [4];
    exp_seg = '{7'h01, 7'h02, 7'h04, 7'h08};
    exp_dot = '{1'b1, 1'b0, 1'b1, 1'b0};
    collect_frame(-1, 7'h00);
    for (int d = 0; d < 4; d++) begin
      compared++; if (lit_cnt[d] != 30) begin mismatched++; $display("FAIL scan_cnt%0d: got %0d want 30", d, lit_cnt[d]); end
      compared++; if (first_pos[d] != 32*d + 2) begin mismatched++; $display("FAIL scan_order%0d: got %0d want %0d", d, first_pos[d], 32*d + 2); end
      compared++; if (seg_seen[d] !== exp_seg[d]) begin mismatched++; $display("FAIL scan_seg%0d: got %h want %h", d, seg_seen[d], exp_seg[d]); end
      compared++; if (dot_seen[d] !== exp_dot[d]) begin mismatched++; $display("FAIL scan_dot%0d: got %b want %b", d, dot_seen[d], exp_dot[d]); end
      compared++; if (seg_var[d] != 0) begin mismatched++; $display("FAIL scan_stable%0d: got %0d changes want 0", d, seg_var[d]); end
    end
    compared++; if (dark_bad != 0 || an_bad != 0) begin mismatched++; $display("FAIL scan_dark_clean: got %0d/%0d bad want 0/0", dark_bad, an_bad); end
    compared++; if (stb_cnt != 1 || stb_pos != 126) begin mismatched++; $display("FAIL scan_stb: got cnt %0d pos %0d want 1 126", stb_cnt, stb_pos); end
  endtask

  task automatic test_brightness();
    bus1.brightness = 4'd4;
    collect_frame(-1, 7'h00);
    collect_frame(-1, 7'h00);
    for (int d = 0; d < 4; d++) begin
      compared++; if (lit_cnt[d] != 8) begin mismatched++; $display("FAIL bright4_cnt%0d: got %0d want 8", d, lit_cnt[d]); end
    end
    compared++; if (first_pos[0] != 2) begin mismatched++; $display("FAIL bright4_start: got %0d want 2", first_pos[0]); end
    bus1.brightness = 4'd0;
    collect_frame(-1, 7'h00);
    collect_frame(-1, 7'h00);
    compared++; if (lit_cnt[0] + lit_cnt[1] + lit_cnt[2] + lit_cnt[3] + an_bad != 0) begin
      mismatched++; $display("FAIL bright0_dark: got %0d lit samples want 0", lit_cnt[0] + lit_cnt[1] + lit_cnt[2] + lit_cnt[3] + an_bad);
    end
    compared++; if (dark_bad != 0) begin mismatched++; $display("FAIL bright0_pins: got %0d bad want 0", dark_bad); end
  endtask

  task automatic test_tear_free();
    bus1.brightness = 4'd15;
    collect_frame(-1, 7'h00);
    collect_frame(10, 7'h7f);
    compared++; if (seg_seen[0] !== 7'h01 || seg_var[0] != 0) begin mismatched++; $display("FAIL tear_old: got %h (%0d changes) want 01", seg_seen[0], seg_var[0]); end
    compared++; if (lit_cnt[0] != 30) begin mismatched++; $display("FAIL tear_old_cnt: got %0d want 30", lit_cnt[0]); end
    compared++; if (stb_cnt != 1) begin mismatched++; $display("FAIL tear_stb: got %0d want 1", stb_cnt); end
    collect_frame(-1, 7'h00);
    compared++; if (seg_seen[0] !== 7'h7f || seg_var[0] != 0) begin mismatched++; $display("FAIL tear_new: got %h (%0d changes) want 7f", seg_seen[0], seg_var[0]); end
  endtask

  task automatic test_blink();
    int exp1 [5];
    exp1 = '{30, 0, 0, 30, 30};
    bus1.blink_mask = 4'b0010;
    for (int f = 0; f < 5; f++) begin
      collect_frame(-1, 7'h00);
      compared++; if (lit_cnt[1] != exp1[f]) begin mismatched++; $display("FAIL blink_d1_f%0d: got %0d want %0d", f, lit_cnt[1], exp1[f]); end
      compared++; if (lit_cnt[0] != 30 || lit_cnt[2] != 30) begin mismatched++; $display("FAIL blink_others_f%0d: got %0d/%0d want 30/30", f, lit_cnt[0], lit_cnt[2]); end
    end
  endtask

  task automatic test_enable();
    repeat (5) tick();
    compared++; if (bus1.an_out !== 4'b1110) begin mismatched++; $display("FAIL en_pre: got %b want 1110", bus1.an_out); end
    bus1.enable = 1'b0;
    tick();
    compared++; if (bus1.an_out !== 4'b1110) begin mismatched++; $display("FAIL en_off_1: got %b want 1110", bus1.an_out); end
    tick();
    compared++; if (bus1.an_out !== 4'b1111 || bus1.seg_out !== 7'h00) begin mismatched++; $display("FAIL en_off_2: got %b/%h want 1111/00", bus1.an_out, bus1.seg_out); end
    bus1.enable = 1'b1;
    tick();
    compared++; if (bus1.an_out !== 4'b1111) begin mismatched++; $display("FAIL en_on_1: got %b want 1111", bus1.an_out); end
    tick();
    compared++; if (bus1.an_out !== 4'b1110 || bus1.seg_out !== 7'h7f) begin mismatched++; $display("FAIL en_on_2: got %b/%h want 1110/7f", bus1.an_out, bus1.seg_out); end
    while (t % 128 != 0) begin
      tick();
      if (t % 128 == 127) begin
        compared++; if (bus1.frame_stb !== 1'b1) begin mismatched++; $display("FAIL en_stb_kept: got %b want 1", bus1.frame_stb); end
      end
    end
  endtask

  task automatic test_n3();
    int         cnt   [3];
    int         first [3];
    logic [6:0] segv  [3];
    logic       dotv  [3];
    logic [6:0] exp_seg [3];
    logic       exp_dot [3];
    int         d;
    int         bad;
    exp_seg = '{7'h7e, 7'h7d, 7'h7b};
    exp_dot = '{1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin cnt[k] = 0; first[k] = -1; segv[k] = '0; dotv[k] = 1'b0; end
    bad = 0;
    while (t % 96 != 0) tick();
    for (int i = 0; i < 96; i++) begin
      tick();
      d = dec3(bus2.an_out);
      if (d >= 0) begin
        if (cnt[d] == 0) begin first[d] = i; segv[d] = bus2.seg_out; dotv[d] = bus2.dot_out; end
        cnt[d]++;
      end else if (d == -1) begin
        if (bus2.seg_out !== 7'h7f || bus2.dot_out !== 1'b1) bad++;
      end else begin
        bad++;
      end
    end
    for (int k = 0; k < 3; k++) begin
      compared++; if (cnt[k] != 30 || first[k] != 32*k + 2) begin mismatched++; $display("FAIL n3_walk%0d: got cnt %0d pos %0d want 30 %0d", k, cnt[k], first[k], 32*k + 2); end
      compared++; if (segv[k] !== exp_seg[k] || dotv[k] !== exp_dot[k]) begin mismatched++; $display("FAIL n3_pins%0d: got %h/%b want %h/%b", k, segv[k], dotv[k], exp_seg[k], exp_dot[k]); end
    end
    compared++; if (bad != 0) begin mismatched++; $display("FAIL n3_dark: got %0d bad samples want 0", bad); end
    repeat (2) tick();
    compared++; if (bus2.an_out !== 3'b000) begin mismatched++; $display("FAIL n3_guard: got %b want 000", bus2.an_out); end
    tick();
    compared++; if (bus2.an_out !== 3'b001) begin mismatched++; $display("FAIL n3_wrap: got %b want 001", bus2.an_out); end
    bus2.enable = 1'b0;
    repeat (2) tick();
    compared++; if (bus2.an_out !== 3'b000 || bus2.seg_out !== 7'h7f || bus2.dot_out !== 1'b1) begin
      mismatched++; $display("FAIL n3_disable: got %b/%h/%b want 000/7f/1", bus2.an_out, bus2.seg_out, bus2.dot_out);
    end
    bus2.enable = 1'b1;
  endtask

  task automatic test_mid_reset();
    int first_stb;
    int dark_viol;
    while (t % 128 != 40) tick();
    rst = 1'b1;
    tick();
    compared++; if (bus1.an_out !== 4'b1111 || bus1.seg_out !== 7'h00 || bus1.frame_stb !== 1'b0) begin
      mismatched++; $display("FAIL midrst_pins: got %b/%h/%b want 1111/00/0", bus1.an_out, bus1.seg_out, bus1.frame_stb);
    end
    rst = 1'b0;
    t = 0;
    first_stb = -1;
    dark_viol = 0;
    for (int i = 0; i < 128; i++) begin
      tick();
      if (bus1.frame_stb === 1'b1 && first_stb < 0) first_stb = t;
      if (bus1.an_out !== 4'b1111) dark_viol++;
    end
    compared++; if (first_stb != 127) begin mismatched++; $display("FAIL midrst_stb: got %0d want 127", first_stb); end
    compared++; if (dark_viol != 0) begin mismatched++; $display("FAIL midrst_dark: got %0d lit samples want 0", dark_viol); end
    collect_frame(-1, 7'h00);
    compared++; if (lit_cnt[0] != 30 || lit_cnt[1] != 30) begin mismatched++; $display("FAIL midrst_restart: got %0d/%0d want 30/30", lit_cnt[0], lit_cnt[1]); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_scan();
    test_brightness();
    test_tear_free();
    test_blink();
    test_enable();
    test_n3();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
